// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: stage states, occupancy width,
// bubble encoding and the fetch/decode bundle field layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int OCC_W = 2;

    // Bubble payload: an all-zero bundle decodes as a no-op in every stage.
    localparam logic [81:0] NOP_ENC = 82'd0;

    localparam int FD_NPC_LSB   = 0;
    localparam int FD_NPC_MSB   = 31;
    localparam int FD_OPC_LSB   = 32;
    localparam int FD_OPC_MSB   = 36;
    localparam int FD_RS_LSB    = 37;
    localparam int FD_RS_MSB    = 39;
    localparam int FD_RD_LSB    = 40;
    localparam int FD_RD_MSB    = 42;
    localparam int FD_SHAMT_LSB = 43;
    localparam int FD_SHAMT_MSB = 47;
    localparam int FD_PC_LSB    = 48;
    localparam int FD_PC_MSB    = 79;
    localparam int FD_INT_LSB   = 80;
    localparam int FD_INT_MSB   = 81;

    function automatic logic [OCC_W-1:0] occ_of(input stage_state_e s);
        logic [OCC_W-1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the optional stage performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with 2-entry skid buffer, flush and sticky interrupt capture.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 82,
    parameter int                INT_W     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_ENC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [INT_W-1:0]  in_int,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [INT_W-1:0]  out_int,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    stage_state_e      state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [INT_W-1:0]  main_int_q,  main_int_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [INT_W-1:0]  skid_int_q,  skid_int_d;
    logic [INT_W-1:0]  pending_q,   pending_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OCC_W-1:0]  occ_q,       occ_d;

    logic              accept_s;
    logic              drain_s;
    logic [INT_W-1:0]  beat_int_s;

    assign accept_s   = in_valid & in_ready_q;
    assign drain_s    = out_valid_q & out_ready;
    assign beat_int_s = pending_q | in_int;

    // Next-state, entry and interrupt-capture logic; flush overrides any transfer.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_int_d  = main_int_q;
        skid_data_d = skid_data_q;
        skid_int_d  = skid_int_q;
        pending_d   = beat_int_s;

        if (flush) begin
            state_d     = EMPTY;
            main_data_d = NOP_VALUE;
            main_int_d  = {INT_W{1'b0}};
            skid_data_d = NOP_VALUE;
            skid_int_d  = {INT_W{1'b0}};
        end else begin
            if (accept_s) begin
                pending_d = {INT_W{1'b0}};
            end else begin
                pending_d = beat_int_s;
            end

            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_data_d = in_data;
                        main_int_d  = beat_int_s;
                        state_d     = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !drain_s) begin
                        skid_data_d = in_data;
                        skid_int_d  = beat_int_s;
                        state_d     = FULL;
                    end else if (accept_s && drain_s) begin
                        main_data_d = in_data;
                        main_int_d  = beat_int_s;
                        state_d     = ONE;
                    end else if (drain_s) begin
                        main_data_d = NOP_VALUE;
                        main_int_d  = {INT_W{1'b0}};
                        state_d     = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can change anything.
                    if (drain_s) begin
                        main_data_d = skid_data_q;
                        main_int_d  = skid_int_q;
                        skid_data_d = NOP_VALUE;
                        skid_int_d  = {INT_W{1'b0}};
                        state_d     = ONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_data_d = NOP_VALUE;
                    main_int_d  = {INT_W{1'b0}};
                    skid_data_d = NOP_VALUE;
                    skid_int_d  = {INT_W{1'b0}};
                end
            endcase
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        occ_d       = occ_of(state_d);
    end

    // Stage state, entries, pending interrupts and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= NOP_VALUE;
            main_int_q  <= {INT_W{1'b0}};
            skid_data_q <= NOP_VALUE;
            skid_int_q  <= {INT_W{1'b0}};
            pending_q   <= {INT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= {OCC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_int_q  <= main_int_d;
            skid_data_q <= skid_data_d;
            skid_int_q  <= skid_int_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    // The main entry is forced to the bubble encoding whenever the stage is empty.
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_int   = main_int_q;
    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~out_ready),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~out_valid_q),
        .clr   (1'b0),
        .cnt   (bubble_cnt)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue-based model compared every cycle, plus literal
// expectations. Covers the PIPE_STAGE_PERF_EN counters when that macro is defined.
module tb_pipe_stage_skid;

    localparam int DW = 82;
    localparam int IW = 2;
    localparam logic [DW-1:0] TB_NOP = 82'h13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_int;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_int;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
    logic [15:0]   flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .INT_W(IW), .NOP_VALUE(TB_NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_int   (out_int),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } beat_t;

    beat_t         mq[$];
    logic [IW-1:0] m_pend;
    int            m_stall, m_bubble, m_flush;
    int            checks   = 0;
    int            failures = 0;
    bit            chk_en   = 1'b0;
    logic [DW-1:0] exp_d;
    logic [IW-1:0] exp_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = '0;
        m_stall  = 0;
        m_bubble = 0;
        m_flush  = 0;
    endtask

    // One clock edge: the model applies the FIFO/flush/interrupt rules to the inputs present at the edge.
    task automatic tick();
        bit            acc, drn, fl, stall, bub;
        logic [DW-1:0] d;
        logic [IW-1:0] irq;
        acc   = in_valid && (mq.size() < 2);
        drn   = (mq.size() > 0) && out_ready;
        fl    = flush;
        d     = in_data;
        irq   = in_int;
        stall = (mq.size() > 0) && !out_ready;
        bub   = (mq.size() == 0);
        @(posedge clk);
        if (stall) m_stall++;
        if (bub)   m_bubble++;
        if (fl)    m_flush++;
        if (fl) begin
            mq.delete();
            m_pend = m_pend | irq;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{d: d, i: m_pend | irq});
                m_pend = '0;
            end else begin
                m_pend = m_pend | irq;
            end
        end
        #1;
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (mq.size() > 0) begin
                exp_d = mq[0].d;
                exp_i = mq[0].i;
            end else begin
                exp_d = TB_NOP;
                exp_i = '0;
            end
            check("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
            check("m_out_data",  128'(out_data),  128'(exp_d));
            check("m_out_int",   128'(out_int),   128'(exp_i));
            check("m_occupancy", 128'(occupancy), 128'(mq.size()));
            check("m_in_ready",  128'(in_ready),  128'(mq.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
            check("m_stall_cnt",  128'(stall_cnt),  128'(m_stall));
            check("m_bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
            check("m_flush_cnt",  128'(flush_cnt),  128'(m_flush));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_int = '0; out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data",  128'(out_data),  128'(TB_NOP));
        check("rst_out_int",   128'(out_int),   128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        #6 rst_n = 1'b1;
        chk_en = 1'b1;

        // Streaming: one beat per cycle, one cycle latency.
        in_valid = 1'b1; in_data = 82'h1234; out_ready = 1'b1;
        tick();
        check("t1_valid", 128'(out_valid), 128'(1));
        check("t1_data",  128'(out_data),  128'(82'h1234));
        check("t1_occ",   128'(occupancy), 128'(1));
        in_data = 82'h1235; tick();
        check("t1_data2", 128'(out_data), 128'(82'h1235));
        in_data = 82'h1236; tick();
        check("t1_data3", 128'(out_data), 128'(82'h1236));
        in_valid = 1'b0; tick();

        // Back-pressure: A and B held, C waits, then all three drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 82'hA;
        tick();
        in_data = 82'hB; tick();
        check("t2_ready_low", 128'(in_ready),  128'(0));
        check("t2_occ2",      128'(occupancy), 128'(2));
        in_data = 82'hC; tick();
        check("t2_head_a", 128'(out_data),  128'(82'hA));
        check("t2_occ2b",  128'(occupancy), 128'(2));
        out_ready = 1'b1; tick();
        check("t2_head_b", 128'(out_data), 128'(82'hB));
        tick();
        check("t2_head_c", 128'(out_data), 128'(82'hC));
        in_valid = 1'b0; tick();
        check("t2_empty", 128'(occupancy), 128'(0));

        // Interrupt pulse while idle rides on the next accepted beat only.
        in_int = 2'b01; tick();
        in_int = 2'b00; tick(); tick();
        in_valid = 1'b1; in_data = 82'hD; tick();
        check("t3_d_data", 128'(out_data), 128'(82'hD));
        check("t3_d_int",  128'(out_int),  128'(2'b01));
        in_data = 82'hE; tick();
        check("t3_e_int", 128'(out_int), 128'(2'b00));
        in_valid = 1'b0; tick();

        // Flush from FULL; the interrupt seen during flush survives.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 82'hF; tick();
        in_data = 82'h10; tick();
        flush = 1'b1; in_data = 82'h11; in_int = 2'b10; tick();
        flush = 1'b0; in_int = 2'b00; in_valid = 1'b0;
        check("t4_valid", 128'(out_valid), 128'(0));
        check("t4_data",  128'(out_data),  128'(TB_NOP));
        check("t4_ready", 128'(in_ready),  128'(1));
        check("t4_occ",   128'(occupancy), 128'(0));
        in_valid = 1'b1; in_data = 82'h12; tick();
        check("t4_int", 128'(out_int), 128'(2'b10));
        in_valid = 1'b0; out_ready = 1'b1; tick();

        // Flush in ONE discards a beat accepted in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 82'h20; tick();
        flush = 1'b1; in_data = 82'h21; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4b_occ", 128'(occupancy), 128'(0));
        tick();

        // Asynchronous reset while FULL.
        in_valid = 1'b1; in_data = 82'h30; tick();
        in_data = 82'h31; tick();
        in_valid = 1'b0;
        check("t5_occ_pre", 128'(occupancy), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 128'(out_valid), 128'(0));
        check("t5_data",  128'(out_data),  128'(TB_NOP));
        check("t5_int",   128'(out_int),   128'(0));
        check("t5_ready", 128'(in_ready),  128'(1));
        check("t5_occ",   128'(occupancy), 128'(0));
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        // Five stalled cycles, then two flushes.
        in_valid = 1'b1; in_data = 82'h40; out_ready = 1'b0; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("t6_stall", 128'(stall_cnt), 128'(5));
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        check("t6_flush", 128'(flush_cnt), 128'(2));
`endif

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
